// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and an operation code from switch-driven load pulses,
// then presents the set to a downstream ALU stage with a valid/ready handshake.
module alu_operand_sequencer #(
  parameter int WIDTH = 3,
  parameter int OPW   = 2,
  parameter int CNTW  = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [OPW-1:0]   op_in,
  input  logic             load,
  input  logic             cancel,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [OPW-1:0]   op,
  output logic             out_valid,
  output logic [1:0]       state,
  output logic [CNTW-1:0]  txn_count
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic            load_q;
  logic            load_edge;
  logic            handshake;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [OPW-1:0]   op_nxt;
  logic [CNTW-1:0]  cnt_nxt;

  assign load_edge = load & ~load_q;
  assign handshake = out_valid & out_ready;
  assign state     = cur_state;

  // load_q resets high so a switch left on across reset is not taken as a request
  always_ff @(posedge clk_2) begin
    if (reset) begin
      cur_state <= WAIT_A;
      load_q    <= 1'b1;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      out_valid <= 1'b0;
      txn_count <= '0;
    end else begin
      cur_state <= nxt_state;
      load_q    <= load;
      a         <= a_nxt;
      b         <= b_nxt;
      op        <= op_nxt;
      out_valid <= (nxt_state == PRESENT);
      txn_count <= cnt_nxt;
    end
  end

  // Priority: cancel, then handshake, then a load request
  always_comb begin
    nxt_state = cur_state;
    a_nxt     = a;
    b_nxt     = b;
    op_nxt    = op;
    cnt_nxt   = txn_count;
    if (cancel) begin
      nxt_state = WAIT_A;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
    end else if (handshake) begin
      nxt_state = WAIT_A;
      cnt_nxt   = txn_count + CNTW'(1);
    end else if (load_edge) begin
      case (cur_state)
        WAIT_A: begin
          a_nxt     = din;
          nxt_state = WAIT_B;
        end
        WAIT_B: begin
          b_nxt     = din;
          nxt_state = WAIT_OP;
        end
        WAIT_OP: begin
          op_nxt    = op_in;
          nxt_state = PRESENT;
        end
        default: nxt_state = cur_state;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: a vector table for the basic entry, handshake
// and cancel behaviour, followed by hand-written held-load, wrap and reset sequences.
module tb_alu_operand_sequencer;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [2:0] din;
  logic [1:0] op_in;
  logic       load;
  logic       cancel;
  logic       out_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic [1:0] state;
  logic [3:0] txn_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] din;
    logic [1:0] op_in;
    logic       load;
    logic       cancel;
    logic       out_ready;
    logic [1:0] e_state;
    logic [2:0] e_a;
    logic [2:0] e_b;
    logic [1:0] e_op;
    logic       e_valid;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs [26];

  alu_operand_sequencer #(.WIDTH(3), .OPW(2), .CNTW(4)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .din       (din),
    .op_in     (op_in),
    .load      (load),
    .cancel    (cancel),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .state     (state),
    .txn_count (txn_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check_output(input string name, input logic [1:0] es, input logic [2:0] ea,
                              input logic [2:0] eb, input logic [1:0] eop, input logic ev,
                              input logic [3:0] ec);
    n_cmp++;
    if ({state, a, b, op, out_valid, txn_count} !== {es, ea, eb, eop, ev, ec}) begin
      n_bad++;
      $display("[TB] FAIL %s: got st=%0d a=%0d b=%0d op=%0d v=%0d cnt=%0d, want st=%0d a=%0d b=%0d op=%0d v=%0d cnt=%0d",
               name, state, a, b, op, out_valid, txn_count, es, ea, eb, eop, ev, ec);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    din       = v.din;
    op_in     = v.op_in;
    load      = v.load;
    cancel    = v.cancel;
    out_ready = v.out_ready;
    tick();
  endtask

  task automatic pulse_load(input logic [2:0] d, input logic [1:0] o);
    din   = d;
    op_in = o;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
  endtask

  initial begin
    // din, op_in, load, cancel, out_ready | state, a, b, op, valid, count
    vecs[0]  = '{3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0};
    vecs[1]  = '{3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0};
    vecs[2]  = '{3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 3'd0, 2'd0, 1'b0, 4'd0};
    vecs[3]  = '{3'd6, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd3, 3'd0, 2'd0, 1'b0, 4'd0};
    vecs[4]  = '{3'd6, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd3, 3'd6, 2'd0, 1'b0, 4'd0};
    vecs[5]  = '{3'd6, 2'd1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd3, 3'd6, 2'd0, 1'b0, 4'd0};
    vecs[6]  = '{3'd6, 2'd1, 1'b1, 1'b0, 1'b0, 2'd3, 3'd3, 3'd6, 2'd1, 1'b1, 4'd0};
    vecs[7]  = '{3'd6, 2'd1, 1'b0, 1'b0, 1'b0, 2'd3, 3'd3, 3'd6, 2'd1, 1'b1, 4'd0};
    vecs[8]  = '{3'd5, 2'd2, 1'b1, 1'b0, 1'b0, 2'd3, 3'd3, 3'd6, 2'd1, 1'b1, 4'd0};
    vecs[9]  = '{3'd5, 2'd2, 1'b0, 1'b0, 1'b0, 2'd3, 3'd3, 3'd6, 2'd1, 1'b1, 4'd0};
    vecs[10] = '{3'd5, 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd6, 2'd1, 1'b0, 4'd1};
    vecs[11] = '{3'd5, 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 3'd6, 2'd1, 1'b0, 4'd1};
    vecs[12] = '{3'd2, 2'd2, 1'b1, 1'b0, 1'b0, 2'd1, 3'd2, 3'd6, 2'd1, 1'b0, 4'd1};
    vecs[13] = '{3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 3'd6, 2'd1, 1'b0, 4'd1};
    vecs[14] = '{3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 3'd2, 3'd1, 2'd1, 1'b0, 4'd1};
    vecs[15] = '{3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 3'd2, 3'd1, 2'd1, 1'b0, 4'd1};
    vecs[16] = '{3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd1};
    vecs[17] = '{3'd1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd1};
    vecs[18] = '{3'd7, 2'd3, 1'b1, 1'b0, 1'b0, 2'd1, 3'd7, 3'd0, 2'd0, 1'b0, 4'd1};
    vecs[19] = '{3'd7, 2'd3, 1'b0, 1'b0, 1'b0, 2'd1, 3'd7, 3'd0, 2'd0, 1'b0, 4'd1};
    vecs[20] = '{3'd4, 2'd3, 1'b1, 1'b0, 1'b0, 2'd2, 3'd7, 3'd4, 2'd0, 1'b0, 4'd1};
    vecs[21] = '{3'd4, 2'd3, 1'b0, 1'b0, 1'b0, 2'd2, 3'd7, 3'd4, 2'd0, 1'b0, 4'd1};
    vecs[22] = '{3'd4, 2'd3, 1'b1, 1'b0, 1'b0, 2'd3, 3'd7, 3'd4, 2'd3, 1'b1, 4'd1};
    vecs[23] = '{3'd4, 2'd3, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd1};
    vecs[24] = '{3'd4, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd1};
    vecs[25] = '{3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 2'd1, 3'd5, 3'd0, 2'd0, 1'b0, 4'd1};

    reset     = 1'b1;
    din       = 3'd0;
    op_in     = 2'd0;
    load      = 1'b1;
    cancel    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_output("reset_state", 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0);
    reset = 1'b0;

    // Load is still high from before reset release; the first rows must not capture
    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_a, vecs[i].e_b,
                   vecs[i].e_op, vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Load held high for 19 more cycles beyond the capturing row
    for (int i = 0; i < 19; i++) begin
      tick();
      check_output($sformatf("held_load%0d", i), 2'd1, 3'd5, 3'd0, 2'd0, 1'b0, 4'd1);
    end
    load = 1'b0;
    tick();
    check_output("held_load_release", 2'd1, 3'd5, 3'd0, 2'd0, 1'b0, 4'd1);

    // Reset mid-entry discards the partial set and clears the counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("reset_mid_entry", 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0);
    tick();
    check_output("reset_idle", 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0);

    // Sixteen complete transactions; the counter reads 15 then wraps to 0
    for (int t = 1; t <= 16; t++) begin
      pulse_load(3'(t), 2'(t));
      pulse_load(3'(t + 1), 2'(t));
      pulse_load(3'(t + 2), 2'(t));
      check_output($sformatf("txn%0d_present", t), 2'd3, 3'(t), 3'(t + 1), 2'(t), 1'b1, 4'(t - 1));
      if (t == 1) begin
        for (int k = 0; k < 10; k++) begin
          tick();
          check_output($sformatf("valid_hold%0d", k), 2'd3, 3'(t), 3'(t + 1), 2'(t), 1'b1, 4'd0);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_output($sformatf("txn%0d_done", t), 2'd0, 3'(t), 3'(t + 1), 2'(t), 1'b0, 4'(t));
    end

    // Reset while presenting clears everything on the next edge
    pulse_load(3'd2, 2'd2);
    pulse_load(3'd5, 2'd2);
    pulse_load(3'd5, 2'd2);
    check_output("pre_reset_present", 2'd3, 3'd2, 3'd5, 2'd2, 1'b1, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("reset_in_present", 2'd0, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, meaning operand width in bits (two's complement).
REQ-002 The block SHALL have parameter OPW, default 2, meaning operation-code width.
REQ-003 The block SHALL have parameter CNTW, default 4, meaning transaction-counter width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port din  input  WIDTH  operand value from switches.
REQ-008 Port op_in  input  OPW  operation code from switches.
REQ-009 Port load  input  1  level from a switch; a rising edge is one capture request.
REQ-010 Port cancel  input  1  level; abort the current entry.
REQ-011 Port out_ready  input  1  downstream ALU stage accepts the operand set.
REQ-012 Port a  output  WIDTH  registered operand A.
REQ-013 Port b  output  WIDTH  registered operand B.
REQ-014 Port op  output  OPW  registered operation code.
REQ-015 Port out_valid  output  1  operand set complete and stable.
REQ-016 Port state  output  2  current FSM state code, for LEDs.
REQ-017 Port txn_count  output  CNTW  count of completed handshakes.

Function
REQ-018 Edge detect: load_q SHALL be a register of load; load_edge = load & ~load_q, combinational.
REQ-019 FSM states and codes SHALL be WAIT_A=0, WAIT_B=1, WAIT_OP=2, PRESENT=3; state output equals the current code.
REQ-020 In WAIT_A, load_edge SHALL capture din into a and move to WAIT_B on the same clock edge.
REQ-021 In WAIT_B, load_edge SHALL capture din into b and move to WAIT_OP.
REQ-022 In WAIT_OP, load_edge SHALL capture op_in into op, move to PRESENT, and set out_valid=1.
REQ-023 out_valid is registered: 1 exactly while state is PRESENT; 1-cycle latency from the third load_edge to out_valid high.
REQ-024 In PRESENT, a, b and op SHALL hold stable; load_edge SHALL be ignored.
REQ-025 Handshake: on a clock edge with out_valid=1 and out_ready=1, the block SHALL move to WAIT_A, clear out_valid and increment txn_count.
REQ-026 out_ready while out_valid=0 SHALL have no effect; out_valid SHALL never drop without a handshake or cancel.
REQ-027 txn_count SHALL wrap from 2^CNTW-1 to 0 (15 -> 0 at default).
REQ-028 cancel=1 in any state SHALL move to WAIT_A, clear out_valid and zero a, b and op on that edge.
REQ-029 Priority: reset > cancel > handshake > load_edge; a cancel coinciding with a handshake SHALL NOT increment txn_count.
REQ-030 Operand registers SHALL store din bit-exact with no sign extension or saturation.
REQ-031 No other register SHALL change when no event occurs (hold).

Reset
REQ-032 On a clock edge with reset=1, the block SHALL set state=WAIT_A, a=b=op=0, out_valid=0 and txn_count=0.
REQ-033 Reset SHALL set load_q=1, so a load held high across reset release produces no capture until it goes low then high.
REQ-034 Reset asserted mid-entry or in PRESENT SHALL discard the partial or presented set without counting it.

Verification
REQ-035 Entry: din=3'b011 with load pulse, din=3'b110 with load pulse, op_in=2'b01 with load pulse, out_ready=0 -> a=3, b=-2, op=1, out_valid=1 one cycle after the third edge and held 10 cycles.
REQ-036 Handshake: from REQ-035, out_ready=1 for one cycle -> out_valid=0, state=0, txn_count=1 the next cycle; load pulses during PRESENT leave a/b/op unchanged.
REQ-037 Held load: load held high for 20 cycles in WAIT_A -> exactly one capture, state=1.
REQ-038 Cancel: cancel=1 in WAIT_OP with load_edge the same cycle -> state=0, a=b=op=0, out_valid=0; cancel together with a handshake -> txn_count unchanged.
REQ-039 Wrap: 16 complete transactions -> txn_count reads 15 then 0.
REQ-040 Reset: load=1 across reset release -> no capture until load goes 0 then 1; reset in PRESENT -> all outputs 0 next cycle.
